// File: rtl/janus_cube_uop_sched_pkg.sv
// Shared types, constants and index helper for the Janus cube uop scheduler.
package cube_pkg;
  localparam int TILE_LOG2 = 4;
  localparam int IDX_W     = 7;

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DRAIN} sched_state_e;

  typedef logic [11:0]      tile_cnt_t;
  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    logic [15:0] m;
    logic [15:0] k;
    logic [15:0] n;
  } matmul_inst_t;

  typedef struct packed {
    idx_t l0a;
    idx_t l0b;
    idx_t acc;
    logic first;
    logic last;
  } cube_uop_t;

  // Row-major linear index a*b + c, wide enough that callers can simply truncate.
  function automatic logic [23:0] lin_idx(tile_cnt_t a, tile_cnt_t b, tile_cnt_t c);
    return ({12'd0, a} * {12'd0, b}) + {12'd0, c};
  endfunction
endpackage

// File: rtl/janus_cube_uop_sched_fifo.sv
// Small first-word-fall-through instruction queue with flush, full and empty flags.
module cube_inst_fifo
  import cube_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  matmul_inst_t din_i,
  output matmul_inst_t dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  matmul_inst_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign dout_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/janus_cube_uop_sched.sv
// MATMUL-to-tile-uop scheduler for the cube systolic array.
// Optional CUBE_SCHED_PERF_EN adds issued-uop and stall performance counters.
module janus_cube_uop_sched #(
  parameter int TILE_LOG2 = cube_pkg::TILE_LOG2,
  parameter int QDEPTH    = 4,
  parameter int MAX_OUT   = 8,
  parameter int IDX_W     = cube_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic [15:0]      inst_m,
  input  logic [15:0]      inst_k,
  input  logic [15:0]      inst_n,
  output logic             uop_valid,
  input  logic             uop_ready,
  output logic [IDX_W-1:0] uop_l0a_idx,
  output logic [IDX_W-1:0] uop_l0b_idx,
  output logic [IDX_W-1:0] uop_acc_idx,
  output logic             uop_first,
  output logic             uop_last,
  input  logic             uop_retire,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             queue_full,
  output logic             queue_empty
`ifdef CUBE_SCHED_PERF_EN
  ,
  output logic [31:0]      perf_uops,
  output logic [31:0]      perf_stall
`endif
);
  import cube_pkg::*;

  localparam int CW = $clog2(MAX_OUT + 1);

  sched_state_e  state_q;
  tile_cnt_t     mt_tiles_q, kt_tiles_q, nt_tiles_q;
  tile_cnt_t     mt_q, nt_q, kt_q;
  tile_cnt_t     mt_d, nt_d, kt_d;
  tile_cnt_t     load_mt, load_kt, load_nt;
  logic [CW-1:0] inflight_q, inflight_d;
  logic          uop_valid_q, done_q;
  cube_uop_t     uop_q;
  matmul_inst_t  inst_in, head;
  logic          q_full, q_empty;
  logic          uop_acc, last_kt, last_nt, last_mt, final_uop;

  function automatic tile_cnt_t tiles(logic [15:0] dim);
    logic [16:0] sum;
    sum = {1'b0, dim} + 17'((1 << TILE_LOG2) - 1);
    return tile_cnt_t'(sum >> TILE_LOG2);
  endfunction

  function automatic cube_uop_t make_uop(tile_cnt_t mt, tile_cnt_t nt, tile_cnt_t kt,
                                         tile_cnt_t ktl, tile_cnt_t ntl);
    cube_uop_t u;
    u.l0a   = idx_t'(lin_idx(mt, ktl, kt));
    u.l0b   = idx_t'(lin_idx(kt, ntl, nt));
    u.acc   = idx_t'(lin_idx(mt, ntl, nt));
    u.first = (kt == '0);
    u.last  = (kt == ktl - 1'b1);
    return u;
  endfunction

  assign inst_in = {inst_m, inst_k, inst_n};

  cube_inst_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inst_valid),
    .pop_i   (state_q == LOAD),
    .flush_i (abort),
    .din_i   (inst_in),
    .dout_o  (head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  assign load_mt = tiles(head.m);
  assign load_kt = tiles(head.k);
  assign load_nt = tiles(head.n);

  assign uop_acc   = uop_valid_q && uop_ready;
  assign last_kt   = (kt_q == kt_tiles_q - 1'b1);
  assign last_nt   = (nt_q == nt_tiles_q - 1'b1);
  assign last_mt   = (mt_q == mt_tiles_q - 1'b1);
  assign final_uop = last_kt && last_nt && last_mt;

  // kt innermost, then nt, then mt.
  always_comb begin
    kt_d = last_kt ? '0 : kt_q + 1'b1;
    nt_d = nt_q;
    mt_d = mt_q;
    if (last_kt) begin
      nt_d = last_nt ? '0 : nt_q + 1'b1;
      if (last_nt) mt_d = mt_q + 1'b1;
    end
  end

  // A retire against an empty array is ignored so the counter cannot wrap.
  always_comb begin
    inflight_d = inflight_q;
    if (uop_acc && !(uop_retire && inflight_q != '0)) inflight_d = inflight_q + 1'b1;
    else if (!uop_acc && uop_retire && inflight_q != '0) inflight_d = inflight_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mt_tiles_q  <= '0;
      kt_tiles_q  <= '0;
      nt_tiles_q  <= '0;
      mt_q        <= '0;
      nt_q        <= '0;
      kt_q        <= '0;
      inflight_q  <= '0;
      uop_valid_q <= 1'b0;
      done_q      <= 1'b0;
      uop_q       <= '0;
    end else begin
      inflight_q <= inflight_d;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: if (!q_empty) state_q <= abort ? DRAIN : LOAD;
        LOAD: begin
          mt_tiles_q <= load_mt;
          kt_tiles_q <= load_kt;
          nt_tiles_q <= load_nt;
          mt_q       <= '0;
          nt_q       <= '0;
          kt_q       <= '0;
          if (abort || load_mt == '0 || load_kt == '0 || load_nt == '0) begin
            state_q <= DRAIN;
          end else begin
            state_q     <= ISSUE;
            uop_valid_q <= 1'b1;
            uop_q       <= make_uop('0, '0, '0, load_kt, load_nt);
          end
        end
        ISSUE: begin
          if (abort) begin
            uop_valid_q <= 1'b0;
            state_q     <= DRAIN;
          end else if (uop_acc && final_uop) begin
            uop_valid_q <= 1'b0;
            state_q     <= DRAIN;
          end else begin
            // Fields only move on acceptance, so they stay put while stalled.
            if (uop_acc) begin
              mt_q  <= mt_d;
              nt_q  <= nt_d;
              kt_q  <= kt_d;
              uop_q <= make_uop(mt_d, nt_d, kt_d, kt_tiles_q, nt_tiles_q);
            end
            uop_valid_q <= (inflight_d < CW'(MAX_OUT));
          end
        end
        DRAIN: begin
          if (inflight_q == '0) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign uop_valid   = uop_valid_q;
  assign uop_l0a_idx = IDX_W'(uop_q.l0a);
  assign uop_l0b_idx = IDX_W'(uop_q.l0b);
  assign uop_acc_idx = IDX_W'(uop_q.acc);
  assign uop_first   = uop_q.first;
  assign uop_last    = uop_q.last;
  assign done        = done_q;
  assign busy        = (state_q != IDLE) || !q_empty;
  assign queue_full  = q_full;
  assign queue_empty = q_empty;
  assign inst_ready  = !q_full;

`ifdef CUBE_SCHED_PERF_EN
  logic [31:0] perf_uops_q, perf_stall_q;
  logic        stall_cyc;

  assign stall_cyc = (state_q == ISSUE) &&
                     ((uop_valid_q && !uop_ready) || inflight_q == CW'(MAX_OUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_uops_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (uop_acc && perf_uops_q != '1)    perf_uops_q  <= perf_uops_q + 1'b1;
      if (stall_cyc && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 1'b1;
    end
  end

  assign perf_uops  = perf_uops_q;
  assign perf_stall = perf_stall_q;
`endif
endmodule
